// File: rtl/video_sd_timing.sv
// Standard-definition composite video timing generator: interlaced or progressive
// sync, burst gate, active-picture strobes and pixel coordinates.
module video_sd_timing #(
    parameter int H_SYNC            = 118,
    parameter int H_BACK_PORCH      = 152,
    parameter int H_ACTIVE          = 1280,
    parameter int H_FRONT_PORCH     = 38,
    parameter int H_VSYNC_PULSE_LEN = 678,
    parameter int H_EQ_PULSE_LEN    = 58,
    parameter int H_BURST_START     = 132,
    parameter int H_BURST_END       = 196,
    parameter int V_HALF_LINES      = 1050,
    parameter int V_EQ_LEN          = 6,
    parameter int V_BLANK_END       = 42,
    parameter int V_ACTIVE_LINES    = 240,
    parameter int HW                = 11,
    parameter int VW                = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          interlace_req,
    output logic          interlace_active,
    output logic          sync_n,
    output logic          color_burst,
    output logic          active,
    output logic          next_pixel,
    output logic          next_line,
    output logic          next_frame,
    output logic          vblank_pulse,
    output logic          current_field,
    output logic [HW-1:0] pix_x,
    output logic [VW-1:0] pix_y
);

    localparam int H_TOTAL = H_SYNC + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;
    localparam int H_HALF  = H_TOTAL / 2;
    localparam int V_FIELD = V_HALF_LINES / 2;
    localparam int VA      = 2 * V_ACTIVE_LINES;
    localparam int HA0     = H_SYNC + H_BACK_PORCH;

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_HALF_LAST = HW'(H_HALF - 1);
    localparam logic [HW-1:0] H_HALF_C    = HW'(H_HALF);
    localparam logic [HW-1:0] H_SYNC_C    = HW'(H_SYNC);
    localparam logic [HW-1:0] H_VS_C      = HW'(H_VSYNC_PULSE_LEN);
    localparam logic [HW-1:0] H_EQ_C      = HW'(H_EQ_PULSE_LEN);
    localparam logic [HW-1:0] HA_START    = HW'(HA0);
    localparam logic [HW-1:0] HA_END      = HW'(HA0 + H_ACTIVE);
    localparam logic [HW-1:0] H_LINE_STB  = HW'(HA0 - 1);
    localparam logic [HW-1:0] H_BST_C     = HW'(H_BURST_START);
    localparam logic [HW-1:0] H_BEN_C     = HW'(H_BURST_END);
    localparam logic [HW-1:0] H_ONE       = HW'(1);

    localparam logic [VW-1:0] V_LAST_I   = VW'(V_HALF_LINES - 1);
    localparam logic [VW-1:0] V_LAST_P   = VW'(V_FIELD - 2);
    localparam logic [VW-1:0] V_B1       = VW'(V_FIELD);
    localparam logic [VW-1:0] V_F0_LAST  = VW'(V_FIELD - 1);
    localparam logic [VW-1:0] V_EQ1      = VW'(V_EQ_LEN);
    localparam logic [VW-1:0] V_EQ2      = VW'(2 * V_EQ_LEN);
    localparam logic [VW-1:0] V_EQ3      = VW'(3 * V_EQ_LEN);
    localparam logic [VW-1:0] V_F0_START = VW'(V_BLANK_END);
    localparam logic [VW-1:0] V_F0_END   = VW'(V_BLANK_END + VA);
    localparam logic [VW-1:0] V_F1_START = VW'(V_FIELD + V_BLANK_END + 1);
    localparam logic [VW-1:0] V_F1_END   = VW'(V_FIELD + V_BLANK_END + 1 + VA);
    localparam logic [VW-1:0] V_ARM0     = VW'(V_BLANK_END - 1);
    localparam logic [VW-1:0] V_ARM1     = VW'(V_FIELD + V_BLANK_END);
    localparam logic [VW-1:0] V_ONE      = VW'(1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          ilace_q, ilace_d;
    logic          field_q, field_d;
    logic          cur_field_q, cur_field_d;
    logic          arm_q, arm_d;

    logic          half_end, wrap, in_vsync, in_eq, sync_low, v_active, h_active;
    logic [VW-1:0] v_last, vrel_sync, vrel_act;
    logic [HW-1:0] hmod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            ilace_q     <= 1'b1;
            field_q     <= 1'b0;
            cur_field_q <= 1'b0;
            arm_q       <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            ilace_q     <= ilace_d;
            field_q     <= field_d;
            cur_field_q <= cur_field_d;
            arm_q       <= arm_d;
        end
    end

    // Sync/burst/active decodes work on the position within the current half-line and field.
    always_comb begin
        half_end  = (hcnt_q == H_HALF_LAST) || (hcnt_q == H_LAST);
        v_last    = ilace_q ? V_LAST_I : V_LAST_P;
        wrap      = half_end && (vcnt_q == v_last);
        hmod      = (hcnt_q >= H_HALF_C) ? (hcnt_q - H_HALF_C) : hcnt_q;
        vrel_sync = field_q ? (vcnt_q - V_B1) : vcnt_q;
        in_vsync  = (vrel_sync >= V_EQ1) && (vrel_sync < V_EQ2);
        in_eq     = (vrel_sync < V_EQ1) || ((vrel_sync >= V_EQ2) && (vrel_sync < V_EQ3));

        if (in_vsync) begin
            sync_low = (hmod < H_VS_C);
        end else if (in_eq) begin
            sync_low = (hmod < H_EQ_C);
        end else begin
            sync_low = (hcnt_q < H_SYNC_C);
        end

        v_active = ((vcnt_q >= V_F0_START) && (vcnt_q < V_F0_END)) ||
                   (field_q && (vcnt_q >= V_F1_START) && (vcnt_q < V_F1_END));
        h_active = (hcnt_q >= HA_START) && (hcnt_q < HA_END);
        vrel_act = vcnt_q - (field_q ? V_F1_START : V_F0_START);

        interlace_active = ilace_q;
        sync_n           = !sync_low;
        color_burst      = v_active && (hcnt_q >= H_BST_C) && (hcnt_q < H_BEN_C);
        active           = v_active && h_active;
        next_pixel       = h_active;
        next_line        = (hcnt_q == H_LINE_STB);
        next_frame       = arm_q && next_line;
        vblank_pulse     = half_end && ((ilace_q && (vcnt_q == V_F0_LAST)) || (vcnt_q == v_last));
        current_field    = cur_field_q && ilace_q;
        pix_x            = active ? (hcnt_q - HA_START) : '0;
        pix_y            = active ? (vrel_act >> 1) : '0;

        hcnt_d      = (hcnt_q == H_LAST) ? '0 : (hcnt_q + H_ONE);
        vcnt_d      = vcnt_q;
        ilace_d     = ilace_q;
        field_d     = field_q;
        cur_field_d = cur_field_q;
        arm_d       = arm_q;

        // Scan mode only changes at the frame wrap so a frame is never cut short.
        if (half_end) begin
            if (wrap) begin
                vcnt_d  = '0;
                ilace_d = interlace_req;
                field_d = 1'b0;
            end else begin
                vcnt_d = vcnt_q + V_ONE;
                if (ilace_q && (vcnt_q == V_F0_LAST)) begin
                    field_d = 1'b1;
                end
            end
        end

        if (arm_q && next_line) begin
            arm_d = 1'b0;
        end
        if (half_end && ((vcnt_q == V_ARM0) || (field_q && (vcnt_q == V_ARM1)))) begin
            arm_d       = 1'b1;
            cur_field_d = field_q;
        end
    end

endmodule

// File: tb/tb_video_sd_timing.sv
// Directed bench for video_sd_timing with default NTSC-like parameters; tracks the
// expected raster position itself and checks outputs at hand-picked points and per frame.
module tb_video_sd_timing;

    logic        clk;
    logic        rst;
    logic        interlace_req;
    logic        interlace_active, sync_n, color_burst, active, next_pixel;
    logic        next_line, next_frame, vblank_pulse, current_field;
    logic [10:0] pix_x;
    logic [10:0] pix_y;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mh = 0;
    int mv = 0;
    bit modelIl = 1'b1;

    int lastNl = -1, nlBad = 0, lastNf0 = -1, frameLen = 0;
    int actLines, actCycles, burstCyc, burstBad, syncLow, vsLow, vsBad;
    int vbCnt, vbBad, nfCnt, nfBad, cfBad, nlCnt;

    video_sd_timing dut (
        .clk              (clk),
        .rst              (rst),
        .interlace_req    (interlace_req),
        .interlace_active (interlace_active),
        .sync_n           (sync_n),
        .color_burst      (color_burst),
        .active           (active),
        .next_pixel       (next_pixel),
        .next_line        (next_line),
        .next_frame       (next_frame),
        .vblank_pulse     (vblank_pulse),
        .current_field    (current_field),
        .pix_x            (pix_x),
        .pix_y            (pix_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d (h=%0d v=%0d)", tag, observed, expected, mh, mv);
        end
    endtask

    task automatic applyStimulus(input logic req);
        interlace_req = req;
    endtask

    task automatic clearStats();
        actLines = 0; actCycles = 0; burstCyc = 0; burstBad = 0; syncLow = 0; vsLow = 0;
        vsBad = 0; vbCnt = 0; vbBad = 0; nfCnt = 0; nfBad = 0; cfBad = 0; nlCnt = 0;
    endtask

    // Per-cycle bookkeeping against hand-derived raster rules.
    task automatic sample();
        int  hm;
        bit  vbExp, nfExp;
        hm    = (mh >= 794) ? mh - 794 : mh;
        vbExp = (modelIl && mh == 793 && mv == 524) || (mh == 1587 && mv == (modelIl ? 1049 : 523));
        nfExp = (mh == 269) && (mv == 42 || (modelIl && mv == 568));
        if (next_line) begin
            if (lastNl >= 0 && (cyc - lastNl) != 1588) nlBad++;
            lastNl = cyc;
            nlCnt++;
        end
        if (active && pix_x == 0) actLines++;
        if (active) actCycles++;
        if (color_burst) begin
            burstCyc++;
            if (mh < 132 || mh > 195 || mv < 18) burstBad++;
        end
        if (!sync_n) begin
            syncLow++;
            if (mv >= 6 && mv <= 11) vsLow++;
        end
        if (mv >= 6 && mv <= 11 && sync_n !== 1'(hm >= 678)) vsBad++;
        if (vblank_pulse !== vbExp) vbBad++;
        if (vblank_pulse) vbCnt++;
        if (next_frame !== nfExp) nfBad++;
        if (next_frame) begin
            nfCnt++;
            if (current_field !== 1'(mv >= 525)) cfBad++;
            if (mv == 42) begin
                if (lastNf0 >= 0) frameLen = cyc - lastNf0;
                lastNf0 = cyc;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst) begin
            if (mh == 793 || mh == 1587) begin
                if (mv == (modelIl ? 1049 : 523)) begin
                    mv = 0;
                    modelIl = interlace_req;
                end else begin
                    mv++;
                end
            end
            mh = (mh == 1587) ? 0 : mh + 1;
        end
        @(negedge clk);
        if (!rst) sample();
    endtask

    task automatic runTo(input int th, input int tv);
        int n;
        n = 0;
        while (!(mh == th && mv == tv) && n < 1000000) begin
            tick();
            n++;
        end
        if (!(mh == th && mv == tv)) begin
            checks++;
            errors++;
            $display("[TB] FAIL reach h=%0d v=%0d: stopped at h=%0d v=%0d", th, tv, mh, mv);
        end
    endtask

    task automatic checkFrame(input bit il);
        checkOutput("frame active lines", actLines, il ? 480 : 240);
        checkOutput("frame active cycles", actCycles, il ? 614400 : 307200);
        checkOutput("frame burst cycles", burstCyc, il ? 30720 : 15360);
        checkOutput("burst outside window", burstBad, 0);
        checkOutput("frame sync low cycles", syncLow, il ? 69354 : 34618);
        checkOutput("vsync low cycles", vsLow, 4068);
        checkOutput("vsync pattern", vsBad, 0);
        checkOutput("vblank count", vbCnt, il ? 2 : 1);
        checkOutput("vblank placement", vbBad, 0);
        checkOutput("next_frame count", nfCnt, il ? 2 : 1);
        checkOutput("next_frame placement", nfBad, 0);
        checkOutput("current_field at next_frame", cfBad, 0);
        checkOutput("next_line count", nlCnt, il ? 525 : 262);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1);
        clearStats();
        repeat (3) @(negedge clk);

        checkOutput("reset interlace_active", interlace_active, 1);
        checkOutput("reset sync_n", sync_n, 0);
        checkOutput("reset next_line", next_line, 0);
        checkOutput("reset next_frame", next_frame, 0);
        checkOutput("reset vblank", vblank_pulse, 0);
        checkOutput("reset pix_x", pix_x, 0);
        checkOutput("reset pix_y", pix_y, 0);

        rst = 1'b0;
        sample();
        checkOutput("release sync_n", sync_n, 0);
        checkOutput("release active", active, 0);

        // Frame 1: interlaced sync shape, burst, first/last active pixels.
        runTo(677, 6);   checkOutput("vsync low end", sync_n, 0);
        runTo(678, 6);   checkOutput("vsync high", sync_n, 1);
        runTo(1471, 7);  checkOutput("vsync 2nd half low", sync_n, 0);
        runTo(1472, 7);  checkOutput("vsync 2nd half high", sync_n, 1);
        runTo(57, 12);   checkOutput("eq low end", sync_n, 0);
        runTo(58, 12);   checkOutput("eq high", sync_n, 1);
        runTo(117, 18);  checkOutput("hsync low end", sync_n, 0);
        runTo(118, 18);  checkOutput("hsync high", sync_n, 1);
        runTo(132, 18);  checkOutput("burst blank line", color_burst, 0);
        runTo(300, 18);  checkOutput("next_pixel blank line", next_pixel, 1);
                         checkOutput("active blank line", active, 0);
        runTo(800, 19);  checkOutput("no mid-line sync", sync_n, 1);
        runTo(1587, 41); checkOutput("next_frame before", next_frame, 0);
        runTo(131, 42);  checkOutput("burst before", color_burst, 0);
        runTo(132, 42);  checkOutput("burst start", color_burst, 1);
        runTo(195, 42);  checkOutput("burst last", color_burst, 1);
        runTo(196, 42);  checkOutput("burst end", color_burst, 0);
        runTo(269, 42);  checkOutput("next_frame f0", next_frame, 1);
                         checkOutput("next_line f0", next_line, 1);
                         checkOutput("current_field f0", current_field, 0);
        runTo(270, 42);  checkOutput("first active", active, 1);
                         checkOutput("first pix_x", pix_x, 0);
                         checkOutput("first pix_y", pix_y, 0);
                         checkOutput("next_frame one cycle", next_frame, 0);
        runTo(1000, 43); checkOutput("pix_x mid", pix_x, 730);
                         checkOutput("pix_y mid", pix_y, 0);
        runTo(1549, 521); checkOutput("last pix_x", pix_x, 1279);
                          checkOutput("last pix_y", pix_y, 239);
        runTo(1550, 521); checkOutput("after last active", active, 0);
                          checkOutput("after last pix_x", pix_x, 0);
        runTo(792, 524); checkOutput("vblank before", vblank_pulse, 0);
        runTo(793, 524); checkOutput("vblank f0", vblank_pulse, 1);
        runTo(269, 568); checkOutput("next_frame f1", next_frame, 1);
                         checkOutput("current_field f1", current_field, 1);
        runTo(270, 568); checkOutput("f1 first pix_y", pix_y, 0);
                         checkOutput("f1 first active", active, 1);
        runTo(1549, 1047); checkOutput("f1 last pix_y", pix_y, 239);
        runTo(1587, 1049); checkOutput("vblank f1", vblank_pulse, 1);
        checkFrame(1'b1);
        clearStats();

        // Frame 2: interlaced; scan-mode request drops mid-frame.
        runTo(270, 42);  checkOutput("frame period interlaced", frameLen, 833700);
        runTo(0, 300);   applyStimulus(1'b0);
        runTo(0, 600);   checkOutput("mode held mid-frame", interlace_active, 1);
        runTo(1587, 1049); checkOutput("mode held at wrap", interlace_active, 1);
        checkFrame(1'b1);
        clearStats();

        // Frame 3: progressive.
        tick();          checkOutput("mode switched", interlace_active, 0);
                         checkOutput("progressive current_field", current_field, 0);
        runTo(269, 42);  checkOutput("progressive next_frame", next_frame, 1);
        runTo(1587, 523); checkOutput("progressive vblank", vblank_pulse, 1);
        checkFrame(1'b0);
        clearStats();

        // Frame 4: progressive length, then asynchronous reset mid-frame.
        runTo(270, 42);  checkOutput("frame period progressive", frameLen, 416056);
        runTo(500, 300); checkOutput("pre-reset active", active, 1);
                         checkOutput("pre-reset pix_x", pix_x, 230);
                         checkOutput("pre-reset pix_y", pix_y, 129);
        rst = 1'b1;
        #1;
        checkOutput("async reset interlace_active", interlace_active, 1);
        checkOutput("async reset active", active, 0);
        checkOutput("async reset pix_x", pix_x, 0);
        checkOutput("async reset pix_y", pix_y, 0);
        checkOutput("async reset sync_n", sync_n, 0);
        checkOutput("async reset next_pixel", next_pixel, 0);
        applyStimulus(1'b1);
        tick();
        tick();
        mh = 0; mv = 0; modelIl = 1'b1; lastNl = -1; lastNf0 = -1;
        clearStats();
        rst = 1'b0;
        sample();
        runTo(57, 0);    checkOutput("restart eq low", sync_n, 0);
        runTo(58, 0);    checkOutput("restart eq high", sync_n, 1);
        runTo(269, 42);  checkOutput("restart next_frame", next_frame, 1);
                         checkOutput("restart current_field", current_field, 0);
        checkOutput("restart next_frame placement", nfBad, 0);
        checkOutput("line period", nlBad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
